// File: rtl/btb_dir_pred.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Registered lookup results; one resolved-branch update and optional full flush per cycle.
module btb_dir_pred #(
  parameter int ADDR_W  = 64,
  parameter int ENTRIES = 32,
  parameter int TAG_W   = 10,
  parameter int CTR_W   = 2,
  parameter int ALIGN   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t              CTR_MAX     = '1;
  localparam ctr_t              CTR_WEAK    = ctr_t'(1) << (CTR_W - 1);
  localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(1) << ALIGN;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_d [ENTRIES];
  ctr_t               ctr_q [ENTRIES];
  ctr_t               ctr_d [ENTRIES];

  logic              pred_valid_q, pred_valid_d;
  logic              pred_hit_q, pred_hit_d;
  logic              pred_taken_q, pred_taken_d;
  logic [ADDR_W-1:0] pred_target_q, pred_target_d;

  logic [IDX_W-1:0] req_idx, upd_idx;
  logic [TAG_W-1:0] req_tag, upd_tag;
  logic             req_hit, upd_hit;
  logic             unused_upd_pc_bits;

  assign req_idx = req_pc[ALIGN +: IDX_W];
  assign req_tag = req_pc[ALIGN+IDX_W +: TAG_W];
  assign upd_idx = upd_pc[ALIGN +: IDX_W];
  assign upd_tag = upd_pc[ALIGN+IDX_W +: TAG_W];

  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign unused_upd_pc_bits = ^upd_pc;

  // Lookup reads only current state, so a same-cycle update is never bypassed.
  always_comb begin
    pred_valid_d  = req_valid;
    pred_hit_d    = pred_hit_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (req_valid) begin
      pred_hit_d    = req_hit;
      pred_taken_d  = req_hit && ctr_q[req_idx][CTR_W-1];
      pred_target_d = pred_taken_d ? tgt_q[req_idx] : (req_pc + INSTR_BYTES);
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          tgt_d[upd_idx] = upd_target;
          if (ctr_q[upd_idx] != CTR_MAX) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + 1'b1;
          end
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 1'b1;
        end
      end else if (upd_taken) begin
        // A taken miss always claims the slot, evicting whatever aliased there.
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        tgt_d[upd_idx]   = upd_target;
        ctr_d[upd_idx]   = CTR_WEAK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      ctr_q         <= ctr_d;
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;

endmodule

// File: tb/tb_btb_dir_pred.sv
// Directed, table-driven bench for btb_dir_pred with default parameters.
// Each vector drives one cycle of inputs and checks the registered outputs after that edge.
module tb_btb_dir_pred;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        rv;
    logic [63:0] rpc;
    logic        uv;
    logic [63:0] upc;
    logic        ut;
    logic [63:0] utgt;
    logic        ev;
    logic        eh;
    logic        et;
    logic [63:0] etgt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] PA   = 64'h1000;
  localparam logic [63:0] PB   = 64'h1080;
  localparam logic [63:0] PC16 = 64'h1040;
  localparam logic [63:0] PW   = 64'hFFFF_FFFF_FFFF_FFFC;

  btb_dir_pred dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_pc     (req_pc),
    .pred_valid (pred_valid),
    .pred_hit   (pred_hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic fl,
                              input logic rv, input logic [63:0] rpc,
                              input logic uv, input logic [63:0] upc,
                              input logic ut, input logic [63:0] utgt,
                              input logic ev, input logic eh,
                              input logic et, input logic [63:0] etgt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.rv = rv; v.rpc = rpc;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.ev = ev; v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic check_val(input string name, input int id,
                           input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  // Drives one cycle away from the rising edge, then samples just after it.
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    reset      = v.rst;
    flush      = v.fl;
    req_valid  = v.rv;
    req_pc     = v.rpc;
    upd_valid  = v.uv;
    upd_pc     = v.upc;
    upd_taken  = v.ut;
    upd_target = v.utgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input vec_t v, input int id);
    check_val("pred_valid",  id, {63'd0, pred_valid}, {63'd0, v.ev});
    check_val("pred_hit",    id, {63'd0, pred_hit},   {63'd0, v.eh});
    check_val("pred_taken",  id, {63'd0, pred_taken}, {63'd0, v.et});
    check_val("pred_target", id, pred_target,         v.etgt);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

    //               rst fl rv rpc   uv upc   ut utgt          ev eh et etgt
    vecs.push_back(mk(1, 0, 1, PA,   1, PA,   1, 64'h2000,     0, 0, 0, 64'h0));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 0, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 0, 0,    1, PA,   1, 64'h2000,     0, 0, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 1, 1, 64'h2000));
    vecs.push_back(mk(0, 0, 0, 0,    1, PA,   0, 0,            0, 1, 1, 64'h2000));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 1, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PA,   1, PA,   0, 0,            1, 1, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 1, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 0, 0,    1, PA,   1, 64'h2000,     0, 1, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 0, 0,    1, PA,   1, 64'h2000,     0, 1, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 0, 0,    1, PA,   1, 64'h2200,     0, 1, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PA,   1, PA,   1, 64'h2200,     1, 1, 1, 64'h2200));
    vecs.push_back(mk(0, 0, 1, PA,   1, PA,   0, 0,            1, 1, 1, 64'h2200));
    vecs.push_back(mk(0, 0, 1, PA,   1, PA,   0, 0,            1, 1, 1, 64'h2200));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 1, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PB,   0, 0,    0, 0,            1, 0, 0, 64'h1084));
    vecs.push_back(mk(0, 0, 0, 0,    1, PB,   0, 64'h3000,     0, 0, 0, 64'h1084));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 1, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 0, 0,    1, PB,   1, 64'h3000,     0, 1, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 0, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PB,   0, 0,    0, 0,            1, 1, 1, 64'h3000));
    vecs.push_back(mk(0, 0, 1, PA,   1, PA,   1, 64'h2000,     1, 0, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 1, 1, 64'h2000));
    vecs.push_back(mk(0, 1, 1, PA,   1, PC16, 1, 64'h4000,     1, 1, 1, 64'h2000));
    vecs.push_back(mk(0, 0, 1, PC16, 0, 0,    0, 0,            1, 0, 0, 64'h1044));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 0, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 0, 0,    1, PA,   1, 64'h2000,     0, 0, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 1, 1, 64'h2000));
    vecs.push_back(mk(1, 0, 1, PA,   1, PC16, 1, 64'h4000,     0, 0, 0, 64'h0));
    vecs.push_back(mk(0, 0, 1, PA,   0, 0,    0, 0,            1, 0, 0, 64'h1004));
    vecs.push_back(mk(0, 0, 1, PC16, 0, 0,    0, 0,            1, 0, 0, 64'h1044));
    vecs.push_back(mk(0, 0, 1, PW,   0, 0,    0, 0,            1, 0, 0, 64'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], i);
    end

    // Allocate the top-of-memory PC, then confirm back-to-back taken predictions.
    apply_stimulus(mk(0, 0, 0, 0,  1, PW, 1, 64'h8,  0, 0, 0, 64'h0));
    check_output(mk(0, 0, 0, 0,  0, 0,  0, 0,      0, 0, 0, 64'h0), 100);
    apply_stimulus(mk(0, 0, 1, PW, 1, PW, 1, 64'h10, 1, 1, 1, 64'h8));
    check_output(mk(0, 0, 1, PW, 0, 0,  0, 0,      1, 1, 1, 64'h8), 101);
    apply_stimulus(mk(0, 0, 1, PW, 0, 0,  0, 0,      1, 1, 1, 64'h10));
    check_output(mk(0, 0, 1, PW, 0, 0,  0, 0,      1, 1, 1, 64'h10), 102);

    // Flush alone, then the same PC must miss and fall through with wrap.
    apply_stimulus(mk(0, 1, 0, 0,  0, 0,  0, 0,      0, 1, 1, 64'h10));
    check_output(mk(0, 1, 0, 0,  0, 0,  0, 0,      0, 1, 1, 64'h10), 103);
    apply_stimulus(mk(0, 0, 1, PW, 0, 0,  0, 0,      1, 0, 0, 64'h0));
    check_output(mk(0, 0, 1, PW, 0, 0,  0, 0,      1, 0, 0, 64'h0), 104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
